// File: rtl/operand2_pkg.sv
// operand2_pkg: shared types and constants for the operand-2 immediate encoder.
// Holds the FSM state enum and the positions of the rotate/immediate fields
// inside the 12-bit shifter-operand word.
package operand2_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SEARCH     = 2'd1,
    SEARCH_INV = 2'd2,
    DONE       = 2'd3
  } op2_enc_state_t;

  localparam int ROT_STEPS = 16;
  localparam int ROT_MSB   = 11;
  localparam int ROT_LSB   = 8;
  localparam int IMM_MSB   = 7;

  // Last rotation index tested before a pass is exhausted.
  localparam logic [3:0] ROT_LAST = 4'(ROT_STEPS - 1);

endpackage

// File: rtl/operand2_rot_match.sv
// operand2_rot_match: combinational test of one candidate rotation.
// Rotates the operand left by 2*rot (the inverse of the decode-side ror) and
// reports whether everything above the low byte is zero. The rotation is built
// from a doubled word so rot=0 is a plain pass-through with no shift-by-32.
module operand2_rot_match
  import operand2_pkg::*;
(
  input  logic [31:0]      operand,
  input  logic [3:0]       rot,
  output logic             match,
  output logic [IMM_MSB:0] imm8
);

  logic [4:0]  shamt;
  logic [63:0] doubled;
  logic [31:0] rotated;

  // Left-rotate by an even amount and test the upper 24 bits for zero.
  always_comb begin
    shamt   = {rot, 1'b0};
    doubled = {operand, operand} << shamt;
    rotated = doubled[63:32];
    match   = (rotated[31:IMM_MSB+1] == '0);
    imm8    = rotated[IMM_MSB:0];
  end

endmodule

// File: rtl/operand2_encoder.sv
// operand2_encoder: iterative search for the rotate_imm/immed_8 encoding of a
// 32-bit constant, one rotation per clock, smallest rotation first.
// Optional feature macro: OPERAND2_INVERT_SEARCH_EN adds a second pass over the
// complemented value (MVN form) and the resp_invert output.
module operand2_encoder
  import operand2_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_value,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_encodable,
`ifdef OPERAND2_INVERT_SEARCH_EN
  output logic        resp_invert,
`endif
  output logic [11:0] resp_shift_operand
);

  op2_enc_state_t state_q;
  op2_enc_state_t state_d;

  logic [31:0]      val_q;
  logic [3:0]       rot_q;
  logic [31:0]      operand;
  logic             match;
  logic [IMM_MSB:0] imm8;
  logic [ROT_MSB:0] packed_op;
  logic             rot_exhausted;

  // Feed the shared matcher the value itself, or its complement in the inverted pass.
  always_comb begin
`ifdef OPERAND2_INVERT_SEARCH_EN
    operand = (state_q == SEARCH_INV) ? ~val_q : val_q;
`else
    operand = val_q;
`endif
    rot_exhausted = (rot_q == ROT_LAST);
    packed_op = '0;
    packed_op[ROT_MSB:ROT_LSB] = rot_q;
    packed_op[IMM_MSB:0] = imm8;
  end

  operand2_rot_match u_rot_match (
    .operand (operand),
    .rot     (rot_q),
    .match   (match),
    .imm8    (imm8)
  );

  // State register; reset abandons any search in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: walk rotations until a match or exhaustion, then hold in DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) state_d = SEARCH;
      end
      SEARCH: begin
        if (match) begin
          state_d = DONE;
        end else if (rot_exhausted) begin
`ifdef OPERAND2_INVERT_SEARCH_EN
          state_d = SEARCH_INV;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef OPERAND2_INVERT_SEARCH_EN
      SEARCH_INV: begin
        if (match || rot_exhausted) state_d = DONE;
      end
`endif
      DONE: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs come straight from the registered state.
  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == DONE);
  end

  // Datapath: capture the request, step the rotation, and latch the result on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q              <= '0;
      rot_q              <= '0;
      resp_encodable     <= 1'b0;
      resp_shift_operand <= '0;
`ifdef OPERAND2_INVERT_SEARCH_EN
      resp_invert        <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            val_q              <= req_value;
            rot_q              <= '0;
            resp_encodable     <= 1'b0;
            resp_shift_operand <= '0;
`ifdef OPERAND2_INVERT_SEARCH_EN
            resp_invert        <= 1'b0;
`endif
          end
        end
        SEARCH: begin
          if (match) begin
            resp_encodable     <= 1'b1;
            resp_shift_operand <= packed_op;
`ifdef OPERAND2_INVERT_SEARCH_EN
            resp_invert        <= 1'b0;
`endif
          end else if (rot_exhausted) begin
            rot_q              <= '0;
            resp_encodable     <= 1'b0;
            resp_shift_operand <= '0;
          end else begin
            rot_q <= rot_q + 4'd1;
          end
        end
`ifdef OPERAND2_INVERT_SEARCH_EN
        SEARCH_INV: begin
          if (match) begin
            resp_encodable     <= 1'b1;
            resp_shift_operand <= packed_op;
            resp_invert        <= 1'b1;
          end else if (rot_exhausted) begin
            resp_encodable     <= 1'b0;
            resp_shift_operand <= '0;
            resp_invert        <= 1'b0;
          end else begin
            rot_q <= rot_q + 4'd1;
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule
